// File: rtl/line_draw_scheduler_pkg.sv
// line_sched_pkg: shared types for the line-draw command scheduler.
//   COORD_W       coordinate width of a line command
//   line_cmd_t    one queued line command (x1, x2, y1, y2)
//   sched_state_t sequencer states
package line_sched_pkg;

  localparam int unsigned COORD_W = 9;

  typedef struct packed {
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] x2;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] y2;
  } line_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RUN
  } sched_state_t;

endpackage

// File: rtl/line_draw_scheduler_fifo.sv
// line_cmd_fifo: DEPTH-deep FIFO of line commands with a show-ahead head.
//   clk_i, rst_i   clock, synchronous active-high reset
//   push_i/wdata_i write request and data (ignored when full)
//   pop_i          remove head entry (ignored when empty)
//   rdata_o        current head entry
//   count_o        number of entries held
//   full_o/empty_o occupancy flags
module line_cmd_fifo
  import line_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  line_cmd_t                wdata_i,
  input  logic                     pop_i,
  output line_cmd_t                rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  line_cmd_t         mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic              push_ok;
  logic              pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/line_draw_scheduler.sv
// line_draw_scheduler: queues line commands and issues them one at a time to
// the line-drawing engine through a start/done handshake, with a watchdog.
//   HCLK, HRESET            clock, synchronous active-high reset
//   in_x1..in_y2, in_valid  incoming command and its strobe
//   in_ready                queue not full
//   eng_x1..eng_y2          registered command presented to the engine
//   eng_start, eng_done     one-cycle start pulse / completion pulse
//   queue_count, idle       occupancy and quiescent status
//   overflow, timeout       sticky error flags (dropped / aborted command)
module line_draw_scheduler
  import line_sched_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned COORD_W = line_sched_pkg::COORD_W,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [COORD_W-1:0]       in_x1,
  input  logic [COORD_W-1:0]       in_x2,
  input  logic [COORD_W-1:0]       in_y1,
  input  logic [COORD_W-1:0]       in_y2,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [COORD_W-1:0]       eng_x1,
  output logic [COORD_W-1:0]       eng_x2,
  output logic [COORD_W-1:0]       eng_y1,
  output logic [COORD_W-1:0]       eng_y2,
  output logic                     eng_start,
  input  logic                     eng_done,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic                     idle,
  output logic                     overflow,
  output logic                     timeout
);

  localparam int unsigned WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  sched_state_t      state_q;
  logic [WD_W-1:0]   wd_q;
  line_cmd_t         eng_q;
  logic              eng_start_q;
  logic              overflow_q;
  logic              timeout_q;

  line_cmd_t         in_cmd;
  line_cmd_t         head;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;

  always_comb begin
    in_cmd    = '0;
    in_cmd.x1 = in_x1;
    in_cmd.x2 = in_x2;
    in_cmd.y1 = in_y1;
    in_cmd.y2 = in_y2;
  end

  assign push     = in_valid && !full;
  assign pop      = (state_q == IDLE) && !empty;
  assign in_ready = !full;

  line_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i   (HCLK),
    .rst_i   (HRESET),
    .push_i  (push),
    .wdata_i (in_cmd),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (queue_count),
    .full_o  (full),
    .empty_o (empty)
  );

  // eng_start is raised on the popping edge so that it is high for the
  // whole ISSUE cycle and nowhere else.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= IDLE;
      wd_q        <= '0;
      eng_q       <= '0;
      eng_start_q <= 1'b0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      eng_start_q <= 1'b0;
      if (in_valid && full) overflow_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (pop) begin
            eng_q       <= head;
            eng_start_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          wd_q    <= '0;
          state_q <= RUN;
        end
        RUN: begin
          // done takes priority over the watchdog terminal count
          if (eng_done) begin
            state_q <= IDLE;
          end else if (wd_q == WD_LAST) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign eng_x1    = eng_q.x1;
  assign eng_x2    = eng_q.x2;
  assign eng_y1    = eng_q.y1;
  assign eng_y2    = eng_q.y2;
  assign eng_start = eng_start_q;
  assign idle      = empty && (state_q == IDLE);
  assign overflow  = overflow_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_line_draw_scheduler.sv
module tb_line_draw_scheduler;

  localparam int DEPTH   = 4;
  localparam int COORD_W = 9;
  localparam int TIMEOUT = 16;

  logic               HCLK = 1'b0;
  logic               HRESET;
  logic [COORD_W-1:0] in_x1, in_x2, in_y1, in_y2;
  logic               in_valid;
  logic               in_ready;
  logic [COORD_W-1:0] eng_x1, eng_x2, eng_y1, eng_y2;
  logic               eng_start;
  logic               eng_done;
  logic [2:0]         queue_count;
  logic               idle, overflow, timeout;
  logic [35:0]        eng_all;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  line_draw_scheduler #(
    .DEPTH  (DEPTH),
    .COORD_W(COORD_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .in_x1      (in_x1),
    .in_x2      (in_x2),
    .in_y1      (in_y1),
    .in_y2      (in_y2),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .eng_x1     (eng_x1),
    .eng_x2     (eng_x2),
    .eng_y1     (eng_y1),
    .eng_y2     (eng_y2),
    .eng_start  (eng_start),
    .eng_done   (eng_done),
    .queue_count(queue_count),
    .idle       (idle),
    .overflow   (overflow),
    .timeout    (timeout)
  );

  assign eng_all = {eng_x1, eng_x2, eng_y1, eng_y2};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // cycle boundary: inputs change just after the rising edge, outputs sampled
  // on the falling edge
  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic smp();
    @(negedge HCLK);
  endtask

  task automatic set_cmd(input logic [35:0] c);
    {in_x1, in_x2, in_y1, in_y2} = c;
  endtask

  task automatic do_reset();
    HRESET   = 1'b1;
    in_valid = 1'b0;
    eng_done = 1'b0;
    set_cmd('0);
    cyc();
    HRESET = 1'b0;
  endtask

  function automatic logic [35:0] pk(input int a, input int b, input int c, input int d);
    return {a[8:0], b[8:0], c[8:0], d[8:0]};
  endfunction

  typedef struct {
    logic [35:0] cmd;
    int          done_at;   // RUN-relative cycle of eng_done (0 = during ISSUE, 99 = never)
    bit          exp_to;
    int          exp_idle;  // cycles after eng_start at which idle reads 1
  } vec_t;

  vec_t vt[6];

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1);
  end

  initial begin
    int          lat, idle_at, n_start, n_busy, to_first;
    int          st[$];
    logic [35:0] sc[$];
    logic [35:0] cmds[6];
    bit          pend;

    vt[0] = '{cmd: pk(10, 200, 20, 150), done_at: 5,  exp_to: 1'b0, exp_idle: 6};
    vt[1] = '{cmd: pk(0, 0, 0, 0),       done_at: 1,  exp_to: 1'b0, exp_idle: 2};
    vt[2] = '{cmd: pk(511, 511, 511, 511), done_at: 15, exp_to: 1'b0, exp_idle: 16};
    vt[3] = '{cmd: pk(1, 2, 3, 4),       done_at: 16, exp_to: 1'b0, exp_idle: 17};
    vt[4] = '{cmd: pk(5, 6, 7, 8),       done_at: 0,  exp_to: 1'b1, exp_idle: 17};
    vt[5] = '{cmd: pk(100, 50, 25, 12),  done_at: 99, exp_to: 1'b1, exp_idle: 17};
    for (int i = 0; i < 6; i++) cmds[i] = pk(i * 37 + 3, 400 - i, i * 11, 250 + i * 40);

    // reset values
    do_reset();
    smp();
    check("rst_eng_start", eng_start, 0);
    check("rst_eng", eng_all, 0);
    check("rst_count", queue_count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_idle", idle, 1);
    check("rst_overflow", overflow, 0);
    check("rst_timeout", timeout, 0);

    // single-command vectors
    for (int i = 0; i < 6; i++) begin
      do_reset();
      set_cmd(vt[i].cmd);
      in_valid = 1'b1;
      eng_done = (vt[i].done_at == 0);
      lat = -1;
      for (int k = 0; k < 8 && lat < 0; k++) begin
        smp();
        if (eng_start) lat = k;
        cyc();
        in_valid = 1'b0;
      end
      eng_done = 1'b0;
      check($sformatf("vec%0d_latency", i), lat, 2);
      check($sformatf("vec%0d_eng", i), eng_all, vt[i].cmd);
      idle_at = -1;
      for (int r = 1; r <= 24 && idle_at < 0; r++) begin
        eng_done = (r == vt[i].done_at);
        smp();
        if (idle) idle_at = r;
        cyc();
      end
      eng_done = 1'b0;
      check($sformatf("vec%0d_idle_at", i), idle_at, vt[i].exp_idle);
      check($sformatf("vec%0d_timeout", i), timeout, vt[i].exp_to);
      check($sformatf("vec%0d_eng_held", i), eng_all, vt[i].cmd);
    end

    // fill and overflow: six back-to-back pushes, engine never finishes
    do_reset();
    for (int k = 0; k < 6; k++) begin
      set_cmd(cmds[k]);
      in_valid = 1'b1;
      smp();
      if (k == 5) begin
        check("fill_count_full", queue_count, 4);
        check("fill_in_ready_low", in_ready, 0);
        check("fill_overflow_before", overflow, 0);
      end
      cyc();
    end
    in_valid = 1'b0;
    smp();
    check("fill_overflow", overflow, 1);
    check("fill_count_after", queue_count, 4);
    check("fill_eng_first", eng_all, cmds[0]);
    check("fill_idle", idle, 0);
    cyc();

    // order and spacing: done pulsed in the first RUN cycle of each command
    do_reset();
    pend = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k < 3) begin
        set_cmd(cmds[k]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      eng_done = pend;
      pend = 1'b0;
      smp();
      if (eng_start) begin
        st.push_back(k);
        sc.push_back(eng_all);
        pend = 1'b1;
      end
      cyc();
    end
    eng_done = 1'b0;
    check("order_nstarts", st.size(), 3);
    if (st.size() == 3) begin
      check("order_first_start", st[0], 2);
      for (int i = 0; i < 3; i++) check($sformatf("order_cmd%0d", i), sc[i], cmds[i]);
      for (int i = 1; i < 3; i++) check($sformatf("order_gap%0d", i), st[i] - st[i-1], 3);
    end

    // watchdog with a second command queued
    do_reset();
    st.delete();
    sc.delete();
    to_first = -1;
    for (int k = 0; k < 40; k++) begin
      if (k < 2) begin
        set_cmd(cmds[k + 3]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      smp();
      if (eng_start) begin
        st.push_back(k);
        sc.push_back(eng_all);
      end
      if (timeout && to_first < 0) to_first = k;
      cyc();
    end
    check("wd_nstarts", st.size(), 2);
    check("wd_timeout_cycle", to_first, 2 + TIMEOUT + 1);
    if (st.size() == 2) begin
      check("wd_first_start", st[0], 2);
      check("wd_second_start", st[1], 2 + TIMEOUT + 2);
      check("wd_second_cmd", sc[1], cmds[4]);
    end

    // reset in RUN with three queued
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_cmd(cmds[k]);
      in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    smp();
    check("rstrun_count_before", queue_count, 3);
    cyc();
    HRESET = 1'b1;
    cyc();
    HRESET = 1'b0;
    eng_done = 1'b1;
    smp();
    check("rstrun_count", queue_count, 0);
    check("rstrun_idle", idle, 1);
    cyc();
    eng_done = 1'b0;
    n_start = 0;
    n_busy = 0;
    for (int k = 0; k < 12; k++) begin
      smp();
      if (eng_start) n_start++;
      if (!idle) n_busy++;
      cyc();
    end
    check("rstrun_no_start", n_start, 0);
    check("rstrun_stays_idle", n_busy, 0);
    check("rstrun_timeout", timeout, 0);

    // push in the same cycle IDLE pops, with two queued
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_cmd(cmds[k]);
      in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    eng_done = 1'b1;   // cycle 3 is the first RUN cycle of cmds[0]
    cyc();
    eng_done = 1'b0;
    set_cmd(cmds[3]);
    in_valid = 1'b1;
    smp();
    check("simul_count_idle", queue_count, 2);
    cyc();
    in_valid = 1'b0;
    smp();
    check("simul_count_after", queue_count, 2);
    check("simul_start", eng_start, 1);
    check("simul_eng", eng_all, cmds[1]);
    cyc();

    // randomized traffic against a queue-based reference model
    begin
      logic [35:0] q[$];
      logic [35:0] m_eng, c;
      logic [63:0] r;
      bit          m_busy, m_ovf, m_to, v, d, rst, ready;
      int          m_start, size0;
      do_reset();
      q.delete();
      m_eng = '0; m_busy = 0; m_ovf = 0; m_to = 0; m_start = -100;
      for (int k = 0; k < 1500; k++) begin
        r = {$urandom(), $urandom()};
        c = r[35:0];
        v = ($urandom_range(0, 2) == 0);
        d = ($urandom_range(0, 11) == 0);
        rst = (k == 700);
        set_cmd(c);
        in_valid = v;
        eng_done = d;
        HRESET = rst;
        size0 = q.size();
        smp();
        check("rnd_eng_start", eng_start, (m_busy && k == m_start));
        check("rnd_eng", eng_all, m_eng);
        check("rnd_count", queue_count, size0);
        check("rnd_in_ready", in_ready, (size0 != DEPTH));
        check("rnd_idle", idle, (!m_busy && size0 == 0));
        check("rnd_overflow", overflow, m_ovf);
        check("rnd_timeout", timeout, m_to);
        if (rst) begin
          q.delete();
          m_eng = '0; m_busy = 0; m_ovf = 0; m_to = 0; m_start = -100;
        end else begin
          ready = (size0 != DEPTH);
          if (!m_busy && size0 > 0) begin
            m_eng = q.pop_front();
            m_busy = 1;
            m_start = k + 1;
          end else if (m_busy && k > m_start) begin
            if (d) begin
              m_busy = 0;
            end else if (k == m_start + TIMEOUT) begin
              m_to = 1;
              m_busy = 0;
            end
          end
          if (v) begin
            if (ready) q.push_back(c);
            else m_ovf = 1;
          end
        end
        cyc();
      end
      HRESET = 1'b0;
      in_valid = 1'b0;
      eng_done = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
